// File: rtl/gba_xlate_pkg.sv
// Shared definitions for the tile hashing path: FNV-1a constants and step
// function, the result record carried through the output FIFO, and FSM states.
package gba_xlate_pkg;

    localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
    localparam logic [31:0] FNV_PRIME  = 32'h01000193;

    typedef struct packed {
        logic [31:0] hash;
        logic [8:0]  tile_index;
        logic        text_region;
    } hash_result_t;

    localparam int RESULT_W = $bits(hash_result_t);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } hash_state_e;

    // One FNV-1a round: fold the byte in, then multiply modulo 2^32.
    function automatic logic [31:0] fnv1a_step(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] mixed;
        mixed = h ^ {24'h000000, b};
        return mixed * FNV_PRIME;
    endfunction

endpackage

// File: rtl/hash_result_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two. A push into a full
// FIFO only lands when a pop happens on the same edge.
module hash_result_fifo
    import gba_xlate_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [RESULT_W-1:0] push_data_i,
    input  logic                pop_i,
    output logic [RESULT_W-1:0] head_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [RESULT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [PW-1:0]       count_q;
    logic [PW-1:0]       count_d;
    logic                do_push_s;
    logic                do_pop_s;

    assign full_o    = (count_q == PW'(DEPTH));
    assign empty_o   = (count_q == {PW{1'b0}});
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; contents are cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {RESULT_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tile_hash_gen.sv
// Streams tile bytes through FNV-1a and queues one result per correctly sized tile.
// Optional macro TILE_HASH_BLANK_SKIP_EN suppresses results for all-zero tiles.
module tile_hash_gen
    import gba_xlate_pkg::*;
#(
    parameter int TILE_SIZE_BYTES = 16,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [8:0]  in_tile_index,
    input  logic        in_text_region,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_hash,
    output logic [8:0]  out_tile_index,
    output logic        out_text_region,
    output logic        err_len,
    output logic        err_overflow
);

    localparam int            CW          = $clog2(TILE_SIZE_BYTES) + 1;
    localparam logic [CW-1:0] TILE_LEN    = CW'(TILE_SIZE_BYTES);
    localparam logic [CW-1:0] TILE_LEN_M1 = CW'(TILE_SIZE_BYTES - 1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    hash_state_e   state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_len_q, err_len_d;
    logic          err_ovf_q, err_ovf_d;

    logic          byte_fire_s;
    logic [31:0]   hash_next_s;
    logic [CW-1:0] count_inc_s;
    logic          blank_tile_s;
    logic          push_s;
    hash_result_t  push_data_s;
    logic [RESULT_W-1:0] head_vec_s;
    hash_result_t  head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;

`ifdef TILE_HASH_BLANK_SKIP_EN
    logic blank_q, blank_d;

    // All bytes so far zero, including the last one on this cycle.
    always_comb begin
        blank_tile_s = blank_q & (in_data == 8'h00);
        blank_d      = blank_q;
        if (!cfg_enable) begin
            blank_d = 1'b1;
        end else if (byte_fire_s) begin
            blank_d = in_last ? 1'b1 : blank_tile_s;
        end else begin
            blank_d = blank_q;
        end
    end

    // Zero-tile tracker register.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 1'b1;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign blank_tile_s = 1'b0;
`endif

    assign byte_fire_s = in_valid & cfg_enable;
    assign hash_next_s = fnv1a_step(acc_q, in_data);
    assign count_inc_s = (count_q == CNT_MAX) ? CNT_MAX : count_q + CW'(1);

    // Tile framing FSM: accumulate, detect length errors, and emit the push request.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        err_len_d   = 1'b0;
        push_s      = 1'b0;
        push_data_s = '{hash: hash_next_s, tile_index: in_tile_index, text_region: in_text_region};
        if (!cfg_enable) begin
            // Disabling abandons any partial tile without flagging it.
            state_d = ST_IDLE;
            acc_d   = FNV_OFFSET;
            count_d = {CW{1'b0}};
        end else if (byte_fire_s && in_last) begin
            state_d = ST_IDLE;
            acc_d   = FNV_OFFSET;
            count_d = {CW{1'b0}};
            if ((state_q != ST_DISCARD) && (count_q == TILE_LEN_M1)) begin
                push_s = ~blank_tile_s;
            end else begin
                err_len_d = 1'b1;
            end
        end else if (byte_fire_s) begin
            case (state_q)
                ST_DISCARD: begin
                    state_d = ST_DISCARD;
                    count_d = count_inc_s;
                end
                ST_IDLE, ST_ACCUM: begin
                    count_d = count_inc_s;
                    if (count_q >= TILE_LEN) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_ACCUM;
                        acc_d   = hash_next_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = FNV_OFFSET;
                    count_d = {CW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign pop_s     = out_ready & ~fifo_empty_s;
    assign err_ovf_d = push_s & fifo_full_s & ~pop_s;

    // FSM, accumulator, counter and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= FNV_OFFSET;
            count_q   <= {CW{1'b0}};
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            err_len_q <= err_len_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    hash_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (out_ready),
        .head_o      (head_vec_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign head_s          = head_vec_s;
    assign out_valid       = ~fifo_empty_s;
    assign out_hash        = head_s.hash;
    assign out_tile_index  = head_s.tile_index;
    assign out_text_region = head_s.text_region;
    assign err_len         = err_len_q;
    assign err_overflow    = err_ovf_q;

endmodule

// File: tb/tb_tile_hash_gen.sv
// Self-checking bench for tile_hash_gen: a 16-byte instance for framing/FIFO
// behaviour and a 1-byte instance for the single-byte known-answer case.
module tb_tile_hash_gen;
    import gba_xlate_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cfg_enable, in_valid, in_last, in_text_region, out_ready;
    logic [7:0]  in_data;
    logic [8:0]  in_tile_index;
    logic        out_valid, out_text_region, err_len, err_overflow;
    logic [31:0] out_hash;
    logic [8:0]  out_tile_index;

    logic        s_in_valid, s_in_last, s_in_text_region, s_out_ready;
    logic [7:0]  s_in_data;
    logic [8:0]  s_in_tile_index;
    logic        s_out_valid, s_out_text_region, s_err_len, s_err_overflow;
    logic [31:0] s_out_hash;
    logic [8:0]  s_out_tile_index;

    int checks = 0;
    int failures = 0;
    int len_pulses = 0;
    int ovf_pulses = 0;
    hash_result_t exp_q[$];
    logic [7:0] tile_bytes [0:31];

    always #5 clk = ~clk;

    tile_hash_gen #(.TILE_SIZE_BYTES(16), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_tile_index(in_tile_index), .in_text_region(in_text_region),
        .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
        .out_tile_index(out_tile_index), .out_text_region(out_text_region),
        .err_len(err_len), .err_overflow(err_overflow)
    );

    tile_hash_gen #(.TILE_SIZE_BYTES(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_last(s_in_last), .in_tile_index(s_in_tile_index), .in_text_region(s_in_text_region),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_hash(s_out_hash),
        .out_tile_index(s_out_tile_index), .out_text_region(s_out_text_region),
        .err_len(s_err_len), .err_overflow(s_err_overflow)
    );

    // Pulse counters, sampled after outputs settle.
    always @(posedge clk) begin
        #2;
        if (err_len === 1'b1) len_pulses++;
        if (err_overflow === 1'b1) ovf_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] fnv_model(input int n);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < n; i++) begin
            h = (h ^ {24'd0, tile_bytes[i]}) * 32'h01000193;
        end
        return h;
    endfunction

    // Drives n bytes (last flagged on byte n-1); optional one-cycle gap after every gap_every bytes.
    task automatic send_tile(input int n, input logic [8:0] idx, input logic txt,
                             input int gap_every, input bit expect_push);
        hash_result_t r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tile_bytes[i]; in_last = (i == n - 1);
            in_tile_index = idx; in_text_region = txt;
            if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i != n - 1) begin
                @(negedge clk);
                in_valid = 1'b0; in_last = 1'b0; in_data = 8'hA5;
            end
        end
        if (expect_push) begin
            r.hash = fnv_model(n); r.tile_index = idx; r.text_region = txt;
            exp_q.push_back(r);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) tile_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_hash !== 32'h0) begin failures++; $display("FAIL reset_out_hash got=%h exp=0", out_hash); end
        if (out_tile_index !== 9'h0) begin failures++; $display("FAIL reset_out_tile_index got=%h exp=0", out_tile_index); end
        if (out_text_region !== 1'b0) begin failures++; $display("FAIL reset_out_text got=%b exp=0", out_text_region); end
        if (err_len !== 1'b0) begin failures++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
        if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err_overflow got=%b exp=0", err_overflow); end
        if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_tile1_out_valid got=%b exp=0", s_out_valid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        s_in_valid = 1'b1; s_in_data = 8'h61; s_in_last = 1'b1; s_in_tile_index = 9'h005;
        @(negedge clk);
        s_in_valid = 1'b0; s_in_last = 1'b0;
        checks += 3;
        if (s_out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", s_out_valid); end
        if (s_out_hash !== 32'hE40C292C) begin failures++; $display("FAIL single_hash got=%h exp=e40c292c", s_out_hash); end
        if (s_out_tile_index !== 9'h005) begin failures++; $display("FAIL single_index got=%h exp=005", s_out_tile_index); end
        @(negedge clk);
    endtask

    task automatic test_gapped_tile();
        hash_result_t e;
        bit extra;
        for (int i = 0; i < 16; i++) tile_bytes[i] = 8'(i);
        send_tile(16, 9'h120, 1'b1, 4, 1'b1);
        e = exp_q.pop_front();
        checks += 5;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL gapped_valid got=%b exp=1", out_valid); end
        if (out_hash !== e.hash) begin failures++; $display("FAIL gapped_hash got=%h exp=%h", out_hash, e.hash); end
        if (out_tile_index !== e.tile_index) begin failures++; $display("FAIL gapped_index got=%h exp=%h", out_tile_index, e.tile_index); end
        if (out_text_region !== 1'b1) begin failures++; $display("FAIL gapped_text got=%b exp=1", out_text_region); end
        extra = 1'b0;
        repeat (4) begin @(negedge clk); if (out_valid !== 1'b0) extra = 1'b1; end
        if (extra) begin failures++; $display("FAIL gapped_single_result got=extra exp=none"); end
    endtask

    task automatic test_short_tile();
        hash_result_t e;
        int l0;
        l0 = len_pulses;
        fill_random(10);
        send_tile(10, 9'h033, 1'b0, 0, 1'b0);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL short_no_valid got=%b exp=0", out_valid); end
        if (err_len !== 1'b1) begin failures++; $display("FAIL short_err_len got=%b exp=1", err_len); end
        @(negedge clk);
        if (err_len !== 1'b0) begin failures++; $display("FAIL short_err_len_width got=%b exp=0", err_len); end
        if (len_pulses - l0 != 1) begin failures++; $display("FAIL short_err_count got=%0d exp=1", len_pulses - l0); end
        fill_random(16);
        send_tile(16, 9'h034, 1'b0, 0, 1'b1);
        e = exp_q.pop_front();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL after_short_valid got=%b exp=1", out_valid); end
        if (out_hash !== e.hash) begin failures++; $display("FAIL after_short_hash got=%h exp=%h", out_hash, e.hash); end
        if (out_tile_index !== e.tile_index) begin failures++; $display("FAIL after_short_index got=%h exp=%h", out_tile_index, e.tile_index); end
        @(negedge clk);
    endtask

    task automatic test_overlength();
        int l0;
        l0 = len_pulses;
        fill_random(17);
        send_tile(17, 9'h0AA, 1'b0, 0, 1'b0);
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL over17_no_valid got=%b exp=0", out_valid); end
        if (err_len !== 1'b1) begin failures++; $display("FAIL over17_err_len got=%b exp=1", err_len); end
        fill_random(24);
        send_tile(24, 9'h0AB, 1'b0, 5, 1'b0);
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL over24_no_valid got=%b exp=0", out_valid); end
        if (len_pulses - l0 != 2) begin failures++; $display("FAIL over_err_count got=%0d exp=2", len_pulses - l0); end
    endtask

    task automatic test_back_to_back();
        hash_result_t e;
        int o0, n;
        o0 = ovf_pulses;
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            fill_random(16);
            send_tile(16, 9'(9'h100 + t), t[0], 0, t < 2);
        end
        checks += 3;
        if (err_overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow_pulse got=%b exp=1", err_overflow); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_held_valid got=%b exp=1", out_valid); end
        if (out_hash !== exp_q[0].hash) begin failures++; $display("FAIL b2b_held_hash got=%h exp=%h", out_hash, exp_q[0].hash); end
        @(negedge clk);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks += 3;
                if (out_hash !== e.hash) begin failures++; $display("FAIL b2b_hash%0d got=%h exp=%h", n, out_hash, e.hash); end
                if (out_tile_index !== e.tile_index) begin failures++; $display("FAIL b2b_index%0d got=%h exp=%h", n, out_tile_index, e.tile_index); end
                if (out_text_region !== e.text_region) begin failures++; $display("FAIL b2b_text%0d got=%b exp=%b", n, out_text_region, e.text_region); end
                n++;
            end
            @(negedge clk);
        end
        checks += 3;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d_left exp=0", exp_q.size()); exp_q.delete(); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty_after got=%b exp=0", out_valid); end
        if (ovf_pulses - o0 != 1) begin failures++; $display("FAIL b2b_overflow_count got=%0d exp=1", ovf_pulses - o0); end
    endtask

    task automatic test_blank_tile();
        hash_result_t e;
        int l0;
        l0 = len_pulses;
        for (int i = 0; i < 16; i++) tile_bytes[i] = 8'h00;
`ifdef TILE_HASH_BLANK_SKIP_EN
        send_tile(16, 9'h1FF, 1'b0, 0, 1'b0);
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL blank_skipped got=%b exp=0", out_valid); end
        @(negedge clk);
        if (len_pulses != l0) begin failures++; $display("FAIL blank_no_err got=%0d exp=0", len_pulses - l0); end
`else
        send_tile(16, 9'h1FF, 1'b0, 0, 1'b1);
        e = exp_q.pop_front();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL blank_valid got=%b exp=1", out_valid); end
        if (out_hash !== e.hash) begin failures++; $display("FAIL blank_hash got=%h exp=%h", out_hash, e.hash); end
        @(negedge clk);
        if (len_pulses != l0) begin failures++; $display("FAIL blank_no_err got=%0d exp=0", len_pulses - l0); end
`endif
    endtask

    task automatic test_reset_mid_tile();
        hash_result_t e;
        fill_random(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tile_bytes[i]; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fill_random(16);
        send_tile(16, 9'h077, 1'b1, 0, 1'b1);
        e = exp_q.pop_front();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_valid got=%b exp=1", out_valid); end
        if (out_hash !== e.hash) begin failures++; $display("FAIL rstmid_hash got=%h exp=%h", out_hash, e.hash); end
        @(negedge clk);
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_single got=%b exp=0", out_valid); end
    endtask

    task automatic test_enable_drop();
        hash_result_t e;
        int l0;
        l0 = len_pulses;
        fill_random(16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tile_bytes[i]; in_last = 1'b0;
        end
        @(negedge clk);
        cfg_enable = 1'b0;
        @(negedge clk);
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        cfg_enable = 1'b1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL endrop_no_valid got=%b exp=0", out_valid); end
        if (len_pulses != l0) begin failures++; $display("FAIL endrop_no_err got=%0d exp=0", len_pulses - l0); end
        fill_random(16);
        send_tile(16, 9'h155, 1'b0, 3, 1'b1);
        e = exp_q.pop_front();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL endrop_valid got=%b exp=1", out_valid); end
        if (out_hash !== e.hash) begin failures++; $display("FAIL endrop_hash got=%h exp=%h", out_hash, e.hash); end
        if (out_tile_index !== e.tile_index) begin failures++; $display("FAIL endrop_index got=%h exp=%h", out_tile_index, e.tile_index); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cfg_enable = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_tile_index = 9'h000; in_text_region = 1'b0;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_in_last = 1'b0; s_in_tile_index = 9'h000;
        s_in_text_region = 1'b0; s_out_ready = 1'b1;
        test_reset();
        test_single_byte();
        test_gapped_tile();
        test_short_tile();
        test_overlength();
        test_back_to_back();
        test_blank_tile();
        test_reset_mid_tile();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_hash_gen.md
TILE_HASH_GEN -- requirements
Module: tile_hash_gen

Interface
REQ-001 SHALL have parameter TILE_SIZE_BYTES, default 16, meaning bytes per tile (16 GB 2bpp, 32 GBA 4bpp).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning output result entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock for the whole block.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_enable  input  1  hashing enabled.
REQ-006 SHALL have port in_valid  input  1  tile byte valid (no backpressure; source cannot stall).
REQ-007 SHALL have port in_data  input  8  tile byte.
REQ-008 SHALL have port in_last  input  1  final byte of tile.
REQ-009 SHALL have port in_tile_index  input  9  tile index, sampled with in_last.
REQ-010 SHALL have port in_text_region  input  1  text-font hint, sampled with in_last.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer (glyph lookup) accepts result.
REQ-013 SHALL have port out_hash  output  32  FNV-1a tile hash.
REQ-014 SHALL have port out_tile_index  output  9  tile index of result.
REQ-015 SHALL have port out_text_region  output  1  text hint of result.
REQ-016 SHALL have port err_len  output  1  one-cycle pulse: tile length mismatch.
REQ-017 SHALL have port err_overflow  output  1  one-cycle pulse: result dropped, FIFO full.

Function
REQ-018 SHALL compute 32-bit FNV-1a: h0 = 0x811C9DC5; per byte h = (h XOR byte) * 0x01000193 mod 2^32.
REQ-019 SHALL consume one byte per cycle when in_valid && cfg_enable; in_valid low cycles (gaps) are legal and leave state unchanged.
REQ-020 SHALL implement states IDLE (accumulator h0, count 0), ACCUM (bytes in flight), DISCARD (overlength; swallow until in_last).
REQ-021 Transitions: IDLE->ACCUM on valid non-last byte; ACCUM->IDLE on in_last; ACCUM->DISCARD when a valid non-last byte would make count exceed TILE_SIZE_BYTES; DISCARD->IDLE on in_last.
REQ-022 On in_last with total count == TILE_SIZE_BYTES, SHALL push {final hash including that byte, in_tile_index, in_text_region} into the FIFO on that clock edge, so out_valid rises the next cycle (latency 1 from last byte).
REQ-023 On in_last with count != TILE_SIZE_BYTES (short, or in DISCARD), SHALL push nothing, pulse err_len next cycle, and return to IDLE.
REQ-024 Byte counter SHALL be $clog2(TILE_SIZE_BYTES)+1 bits and saturate rather than wrap.
REQ-025 Output SHALL be valid/ready; out_* stable while out_valid && !out_ready; pop on out_valid && out_ready.
REQ-026 Push with FIFO full and no simultaneous pop SHALL drop the new result and pulse err_overflow next cycle; push and pop in the same cycle when full SHALL succeed.
REQ-027 When cfg_enable is low, input SHALL be ignored and the FSM forced to IDLE; FIFO contents SHALL continue to drain.
REQ-028 Deasserting cfg_enable mid-tile SHALL abandon that tile silently (no error pulse).

Reset
REQ-029 rst SHALL set FSM IDLE, accumulator 0x811C9DC5, count 0, FIFO empty, out_valid 0, out_hash 0, out_tile_index 0, out_text_region 0, err_len 0, err_overflow 0.
REQ-030 rst asserted mid-tile SHALL discard the partial tile; FIFO contents SHALL be lost.

Configuration
REQ-031 With macro TILE_HASH_BLANK_SKIP_EN defined, a complete tile whose bytes are all 0x00 SHALL NOT be pushed (no error pulse); without it, blank tiles SHALL be hashed and pushed like any other tile.

Structure
REQ-032 FNV offset/prime constants, the result struct {hash, tile_index, text_region}, and the FSM state enum SHALL reside in shared package gba_xlate_pkg.
REQ-033 Output buffering SHALL be sub-module hash_result_fifo (synchronous, FIFO_DEPTH entries, full/empty flags).

Verification
REQ-034 TILE_SIZE_BYTES=1, byte 0x61 with in_last, index 0x005 -> next cycle out_valid=1, out_hash=0xE40C292C, out_tile_index=0x005.
REQ-035 16 bytes 0x00..0x0F with 3 gap cycles, index 0x120, text=1 -> out_hash equals software FNV-1a model, out_text_region=1, exactly one result.
REQ-036 in_last on byte 10 of 16 -> no out_valid, err_len pulses one cycle; next 16-byte tile hashes correctly.
REQ-037 out_ready=0, three back-to-back complete tiles (FIFO_DEPTH=2) -> first two retained in order, err_overflow pulses once on the third.
REQ-038 16 bytes 0x00: with TILE_HASH_BLANK_SKIP_EN -> no out_valid; without -> one result matching model.
REQ-039 rst asserted after byte 8 of a tile, then a fresh full tile -> single result equal to the model hash of the fresh tile only.
